// File: rtl/encode_disparity_lanes.sv
// Multi-lane running-disparity encoder: per lane, payload is optionally
// inverted to pull the running disparity back toward zero; the inversion
// flag is prepended above the pass-through header bits.
module encode_disparity_lanes #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned HDR_W       = 2,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned RD_W        = $clog2(DATA_W) + 2
) (
    input  logic                               USER_CLK,
    input  logic                               SYSTEM_RESET_N,
    input  logic                               PASSTHROUGH,
    input  logic                               RD_CLEAR,
    input  logic [LANES*DATA_W-1:0]            DATA_IN,
    input  logic [LANES*HDR_W-1:0]             HEADER_IN,
    input  logic                               DATA_IN_VALID,
    output logic                               DATA_IN_READY,
    output logic [LANES*(DATA_W+HDR_W+1)-1:0]  DATA_OUT,
    output logic                               DATA_OUT_VALID,
    input  logic                               DATA_OUT_READY,
    output logic [LANES*RD_W-1:0]              RD_OUT
);

    localparam int unsigned OUT_W = DATA_W + HDR_W + 1;
    localparam int unsigned POP_W = $clog2(DATA_W) + 1;

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    // Word presented to the decision stage
    logic                     dec_valid;
    logic [LANES*DATA_W-1:0]  dec_payload;
    logic [LANES*HDR_W-1:0]   dec_hdr;
    logic [LANES*POP_W-1:0]   dec_pop;
    logic                     dec_pt;

    logic                     out_ready_c;
    logic                     dec_fire_c;
    logic [LANES*POP_W-1:0]   in_pop_c;
    logic [LANES*OUT_W-1:0]   enc_c;
    logic [LANES-1:0][RD_W-1:0] rd_q;
    logic [LANES-1:0][RD_W-1:0] rd_next_c;

    // Per-lane scratch for the decision logic
    logic [POP_W-1:0]   pop_c;
    logic [RD_W-1:0]    wd_c;
    logic [RD_W-1:0]    rd_c;
    logic [DATA_W-1:0]  payload_c;
    logic               inv_c;
    logic               rd_pos_c, rd_neg_c, wd_pos_c, wd_neg_c;

    // Output register can take a new word when empty or being drained
    assign out_ready_c = !DATA_OUT_VALID || DATA_OUT_READY;
    assign dec_fire_c  = dec_valid && out_ready_c;

    // Popcount of each incoming lane
    always_comb begin
        in_pop_c = '0;
        for (int k = 0; k < LANES; k++) begin
            in_pop_c[k*POP_W +: POP_W] = popcount(DATA_IN[k*DATA_W +: DATA_W]);
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic                     s1_valid;
            logic [LANES*DATA_W-1:0]  s1_payload;
            logic [LANES*HDR_W-1:0]   s1_hdr;
            logic [LANES*POP_W-1:0]   s1_pop;
            logic                     s1_pt;

            assign DATA_IN_READY = !s1_valid || out_ready_c;

            // Stage 1: capture word, header, popcount and passthrough mode
            always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
                if (!SYSTEM_RESET_N) begin
                    s1_valid   <= 1'b0;
                    s1_payload <= '0;
                    s1_hdr     <= '0;
                    s1_pop     <= '0;
                    s1_pt      <= 1'b0;
                end else if (DATA_IN_VALID && DATA_IN_READY) begin
                    s1_valid   <= 1'b1;
                    s1_payload <= DATA_IN;
                    s1_hdr     <= HEADER_IN;
                    s1_pop     <= in_pop_c;
                    s1_pt      <= PASSTHROUGH;
                end else if (out_ready_c) begin
                    s1_valid   <= 1'b0;
                end
            end

            assign dec_valid   = s1_valid;
            assign dec_payload = s1_payload;
            assign dec_hdr     = s1_hdr;
            assign dec_pop     = s1_pop;
            assign dec_pt      = s1_pt;
        end else begin : g_pipe1
            assign DATA_IN_READY = out_ready_c;
            assign dec_valid     = DATA_IN_VALID;
            assign dec_payload   = DATA_IN;
            assign dec_hdr       = HEADER_IN;
            assign dec_pop       = in_pop_c;
            assign dec_pt        = PASSTHROUGH;
        end
    endgenerate

    // Inversion decision and running-disparity update per lane
    always_comb begin
        enc_c     = '0;
        rd_next_c = rd_q;
        pop_c     = '0;
        wd_c      = '0;
        rd_c      = '0;
        payload_c = '0;
        inv_c     = 1'b0;
        rd_pos_c  = 1'b0;
        rd_neg_c  = 1'b0;
        wd_pos_c  = 1'b0;
        wd_neg_c  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            pop_c     = dec_pop[k*POP_W +: POP_W];
            wd_c      = RD_W'({pop_c, 1'b0}) - RD_W'(DATA_W);
            rd_c      = rd_q[k];
            rd_neg_c  = rd_c[RD_W-1];
            rd_pos_c  = !rd_c[RD_W-1] && (rd_c != '0);
            wd_neg_c  = wd_c[RD_W-1];
            wd_pos_c  = !wd_c[RD_W-1] && (wd_c != '0);
            inv_c     = !dec_pt && ((rd_pos_c && wd_pos_c) || (rd_neg_c && wd_neg_c));
            payload_c = dec_payload[k*DATA_W +: DATA_W];
            enc_c[k*OUT_W +: OUT_W] = {inv_c, dec_hdr[k*HDR_W +: HDR_W],
                                       inv_c ? ~payload_c : payload_c};
            if (inv_c) begin
                rd_next_c[k] = rd_c - wd_c;
            end else if (!dec_pt) begin
                rd_next_c[k] = rd_c + wd_c;
            end
        end
    end

    // Output register and running disparity; clear overrides the update
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            DATA_OUT       <= '0;
            DATA_OUT_VALID <= 1'b0;
            rd_q           <= '0;
        end else begin
            if (dec_fire_c) begin
                DATA_OUT       <= enc_c;
                DATA_OUT_VALID <= 1'b1;
            end else if (DATA_OUT_READY) begin
                DATA_OUT_VALID <= 1'b0;
            end
            if (RD_CLEAR) begin
                rd_q <= '0;
            end else if (dec_fire_c) begin
                rd_q <= rd_next_c;
            end
        end
    end

    assign RD_OUT = rd_q;

endmodule
